// File: rtl/ft2232h_pkg.sv
// FT2232H 245-sync FIFO transmitter: shared encodings.
// FSM states, bus width and inactive pin levels.
package ft2232h_pkg;

  localparam int BUS_W = 8;

  localparam logic RD_N_OFF   = 1'b1;
  localparam logic OE_N_OFF   = 1'b1;
  localparam logic WR_N_OFF   = 1'b1;
  localparam logic SIWU_N_OFF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SIWU  = 2'd3
  } ft_state_e;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ft_sync_fifo.sv
// Show-ahead synchronous FIFO, DEPTH x W, power-of-two depth.
// Registered occupancy drives full/empty.
module ft_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ft2232h_tx_stream.sv
// FT2232H 245-sync FIFO transmitter: stream in, bytes out LSB first,
// TXE# flow control and SIWU# flush after an idle period.
module ft2232h_tx_stream
  import ft2232h_pkg::*;
#(
  parameter int IN_BYTES  = 1,
  parameter int DEPTH     = 16,
  parameter int SIWU_IDLE = 32,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  input  logic [8*IN_BYTES-1:0]   s_data,
  output logic                    s_ready,
  input  logic                    txe_n,
  output logic [BUS_W-1:0]        data,
  output logic                    wr_n,
  output logic                    rd_n,
  output logic                    oe_n,
  output logic                    siwu_n,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        bytes_sent,
  output logic                    busy
);

  localparam int IN_W = 8 * IN_BYTES;
  localparam int BW   = clog2_min1(IN_BYTES);
  localparam int IW   = clog2_min1(SIWU_IDLE);

  localparam logic [BW-1:0] LAST_IDX  = BW'(IN_BYTES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(SIWU_IDLE - 1);

  ft_state_e        r_state;
  ft_state_e        w_next;
  logic             r_run;
  logic             r_ovalid;
  logic [BUS_W-1:0] r_obyte;
  logic [IN_W-1:0]  r_rest;
  logic [BW-1:0]    r_bidx;
  logic [IW-1:0]    r_idle;
  logic [CNT_W-1:0] r_sent;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_siwu;
  logic [IN_W-1:0]  w_rdata;

  ft_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (IN_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_wdata (s_data),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  // r_run keeps s_ready low until the first edge after reset release
  assign s_ready  = r_run & ~w_full;
  assign w_push   = s_valid & s_ready;
  assign w_accept = r_ovalid & ~txe_n;
  assign w_last   = (r_bidx == LAST_IDX);

  // Refill on an empty slot or in the same edge the last byte leaves
  assign w_load = ~w_empty & (r_state != ST_SIWU)
                & (~r_ovalid | (w_accept & w_last));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_siwu = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load) w_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_accept & w_last & ~w_load) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_load)              w_next = ST_SEND;
        else if (SIWU_IDLE == 0) w_next = ST_IDLE;
        else if (r_idle == IDLE_LAST) w_next = ST_SIWU;
      end
      ST_SIWU: begin
        w_siwu = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run    <= 1'b0;
      r_ovalid <= 1'b0;
      r_obyte  <= '0;
      r_rest   <= '0;
      r_bidx   <= '0;
      r_idle   <= '0;
      r_sent   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) r_sent <= r_sent + 1'b1;
      if (w_load) begin
        r_ovalid <= 1'b1;
        r_obyte  <= w_rdata[7:0];
        r_rest   <= w_rdata >> 8;
        r_bidx   <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_ovalid <= 1'b0;
        end else begin
          r_obyte <= r_rest[7:0];
          r_rest  <= r_rest >> 8;
          r_bidx  <= r_bidx + 1'b1;
        end
      end
      if (r_state == ST_DRAIN && w_next == ST_DRAIN)
        r_idle <= r_idle + 1'b1;
      else
        r_idle <= '0;
    end
  end

  assign wr_n = (r_ovalid & ~txe_n & ~w_siwu) ? ~WR_N_OFF : WR_N_OFF;
  assign siwu_n     = w_siwu ? ~SIWU_N_OFF : SIWU_N_OFF;
  assign rd_n       = RD_N_OFF;
  assign oe_n       = OE_N_OFF;
  assign data       = r_obyte;
  assign bytes_sent = r_sent;
  assign busy       = ~w_empty | r_ovalid;

endmodule

// File: tb/tb_ft2232h_tx_stream.sv
// Bench for ft2232h_tx_stream: byte-queue reference model,
// vector table for 4-byte words, directed flush/full/reset sequences.
module tb_ft2232h_tx_stream;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // DUT A: 1-byte words, DEPTH 16, flush after 32 idle cycles
  logic        a_s_valid = 1'b0;
  logic [7:0]  a_s_data = '0;
  logic        a_s_ready;
  logic        a_txe_n = 1'b1;
  logic [7:0]  a_data;
  logic        a_wr_n, a_rd_n, a_oe_n, a_siwu_n, a_busy;
  logic [4:0]  a_level;
  logic [31:0] a_bytes_sent;

  // DUT B: 4-byte words, DEPTH 4, no flush, 8-bit counter
  logic        b_s_valid = 1'b0;
  logic [31:0] b_s_data = '0;
  logic        b_s_ready;
  logic        b_txe_n = 1'b1;
  logic [7:0]  b_data;
  logic        b_wr_n, b_rd_n, b_oe_n, b_siwu_n, b_busy;
  logic [2:0]  b_level;
  logic [7:0]  b_bytes_sent;

  ft2232h_tx_stream #(
    .IN_BYTES(1), .DEPTH(16), .SIWU_IDLE(32), .CNT_W(32)
  ) u_a (
    .clk(clk), .reset_n(reset_n),
    .s_valid(a_s_valid), .s_data(a_s_data), .s_ready(a_s_ready),
    .txe_n(a_txe_n), .data(a_data), .wr_n(a_wr_n),
    .rd_n(a_rd_n), .oe_n(a_oe_n), .siwu_n(a_siwu_n),
    .level(a_level), .bytes_sent(a_bytes_sent), .busy(a_busy)
  );

  ft2232h_tx_stream #(
    .IN_BYTES(4), .DEPTH(4), .SIWU_IDLE(0), .CNT_W(8)
  ) u_b (
    .clk(clk), .reset_n(reset_n),
    .s_valid(b_s_valid), .s_data(b_s_data), .s_ready(b_s_ready),
    .txe_n(b_txe_n), .data(b_data), .wr_n(b_wr_n),
    .rd_n(b_rd_n), .oe_n(b_oe_n), .siwu_n(b_siwu_n),
    .level(b_level), .bytes_sent(b_bytes_sent), .busy(b_busy)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: every accepted word becomes its bytes, LSB first
  logic [7:0] a_exp[$];
  logic [7:0] b_exp[$];
  logic [7:0] b_got[$];
  int a_cnt = 0, b_cnt = 0;
  int a_siwu_cnt = 0, b_siwu_cnt = 0;
  int a_wr_first = -1, a_wr_last = 0, a_siwu_gap = 0;
  int b_push_cyc = 0, b_first_cyc = 0, b_last_cyc = 0;

  always @(negedge clk) if (reset_n) begin
    if (a_s_valid && a_s_ready) a_exp.push_back(a_s_data);
    if (!a_wr_n) begin
      chk("a_wr_txe", a_txe_n, 0);
      chk("a_q_nonempty", a_exp.size() > 0, 1);
      if (a_exp.size() > 0) chk("a_byte", a_data, a_exp.pop_front());
      a_cnt++;
      if (a_wr_first < 0) a_wr_first = cyc;
      a_wr_last = cyc;
    end
    if (!a_siwu_n) begin
      chk("a_siwu_wr", a_wr_n, 1);
      a_siwu_cnt++;
      a_siwu_gap = cyc - a_wr_last;
    end
  end

  always @(negedge clk) if (reset_n) begin
    if (b_s_valid && b_s_ready) begin
      for (int i = 0; i < 4; i++) b_exp.push_back(b_s_data[8*i +: 8]);
      b_push_cyc = cyc;
    end
    if (!b_wr_n) begin
      chk("b_wr_txe", b_txe_n, 0);
      chk("b_q_nonempty", b_exp.size() > 0, 1);
      if (b_exp.size() > 0) chk("b_byte", b_data, b_exp.pop_front());
      if (b_got.size() == 0) b_first_cyc = cyc;
      b_got.push_back(b_data);
      b_last_cyc = cyc;
      b_cnt++;
    end
    if (!b_siwu_n) b_siwu_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] w);
    int k = 0;
    a_s_valid = 1'b1;
    a_s_data  = w;
    do begin @(negedge clk); k++; end while (!a_s_ready && k < 50);
    chk("a_push_ready", a_s_ready, 1);
    @(posedge clk); #1;
    a_s_valid = 1'b0;
  endtask

  task automatic push_b(input logic [31:0] w);
    int k = 0;
    b_s_valid = 1'b1;
    b_s_data  = w;
    do begin @(negedge clk); k++; end while (!b_s_ready && k < 50);
    chk("b_push_ready", b_s_ready, 1);
    @(posedge clk); #1;
    b_s_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int max);
    int k = 0;
    while ((a_busy || a_exp.size() != 0) && k < max) begin
      @(negedge clk); k++;
    end
    chk("a_idle", a_busy, 0);
    chk("a_exp_left", a_exp.size(), 0);
    chk("a_sent_vs_model", a_bytes_sent, 32'(a_cnt));
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_b(input int max);
    int k = 0;
    while ((b_busy || b_exp.size() != 0) && k < max) begin
      @(negedge clk); k++;
    end
    chk("b_idle", b_busy, 0);
    chk("b_exp_left", b_exp.size(), 0);
    chk("b_sent_vs_model", b_bytes_sent, 8'(b_cnt));
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] seq;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt [4];

  initial begin
    int acc, c0, s0, na, nb;
    bit ta, tb;

    // word, bus order (first byte in MSB), bytes_sent afterwards
    vt[0] = '{32'h44332211, 32'h11223344, 8'd4};
    vt[1] = '{32'hDEADBEEF, 32'hEFBEADDE, 8'd8};
    vt[2] = '{32'h000000FF, 32'hFF000000, 8'd12};
    vt[3] = '{32'h80000001, 32'h01000080, 8'd16};

    // reset held with s_valid asserted
    a_s_valid = 1'b1; a_s_data = 8'h5A; a_txe_n = 1'b0;
    b_s_valid = 1'b1; b_s_data = 32'h12345678; b_txe_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_a_wr_n", a_wr_n, 1);
    chk("rst_a_siwu_n", a_siwu_n, 1);
    chk("rst_a_rd_n", a_rd_n, 1);
    chk("rst_a_oe_n", a_oe_n, 1);
    chk("rst_a_s_ready", a_s_ready, 0);
    chk("rst_a_sent", a_bytes_sent, 0);
    chk("rst_a_level", a_level, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_wr_n", b_wr_n, 1);
    chk("rst_b_rd_oe", {b_rd_n, b_oe_n}, 2'b11);
    chk("rst_b_s_ready", b_s_ready, 0);
    chk("rst_b_sent", b_bytes_sent, 0);
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    chk("a_ready_before_edge", a_s_ready, 0);
    @(negedge clk);
    chk("a_ready_after_edge", a_s_ready, 1);
    chk("b_ready_after_edge", b_s_ready, 1);
    @(posedge clk); #1;

    // 70 back-to-back single-byte words
    a_wr_first = -1;
    c0 = a_cnt;
    for (int i = 0; i < 70; i++) push_a(8'(i));
    wait_idle_a(100);
    chk("a1_count", a_cnt - c0, 70);
    chk("a1_span", a_wr_last - a_wr_first + 1, 70);
    chk("a1_sent", a_bytes_sent, 70);
    idle(60);
    chk("a1_siwu_cnt", a_siwu_cnt, 1);
    chk("a1_siwu_gap", a_siwu_gap, 33);

    // flush: 32 idle cycles separate last write and SIWU#
    for (int s = 0; s < 2; s++) begin
      s0 = a_siwu_cnt;
      if (s == 0) begin
        push_a(8'hC0); push_a(8'hC1); push_a(8'hC2);
      end else begin
        push_a(8'hD0); push_a(8'hD1);
        wait_idle_a(20);
        idle(10);
        push_a(8'hD2);
      end
      wait_idle_a(20);
      idle(80);
      chk("siwu_once", a_siwu_cnt - s0, 1);
      chk("siwu_gap", a_siwu_gap, 33);
    end

    // fill with TXE# high: 16 in FIFO plus one in the output byte
    a_txe_n = 1'b1;
    acc = 0;
    c0 = a_cnt;
    for (int c = 0; c < 25; c++) begin
      a_s_data  = 8'(8'hA0 + acc);
      a_s_valid = (acc < 20);
      @(negedge clk);
      if (a_s_valid && a_s_ready) acc++;
      @(posedge clk); #1;
    end
    repeat (3) begin
      @(negedge clk);
      chk("full_hold_data", a_data, 8'hA0);
      chk("full_hold_wr", a_wr_n, 1);
      chk("full_ready", a_s_ready, 0);
    end
    chk("full_acc", acc, 17);
    chk("full_level", a_level, 16);
    chk("full_busy", a_busy, 1);
    @(posedge clk); #1;
    a_txe_n = 1'b0;
    @(negedge clk);
    chk("full_pop_no_wt", a_s_ready, 0);
    chk("full_wr_go", a_wr_n, 0);
    @(negedge clk);
    chk("full_ready_back", a_s_ready, 1);
    @(posedge clk); #1;
    a_s_valid = 1'b0;
    wait_idle_a(100);
    chk("full_delivered", a_cnt - c0, 18);

    // 4-byte word vectors
    for (int i = 0; i < 4; i++) begin
      b_txe_n = 1'b0;
      b_got.delete();
      push_b(vt[i].word);
      wait_idle_b(20);
      chk("vec_nbytes", b_got.size(), 4);
      for (int j = 0; j < 4 && j < b_got.size(); j++)
        chk("vec_byte", b_got[j], vt[i].seq[31-8*j -: 8]);
      // handshake edge to ovalid edge is one clock
      chk("vec_latency", b_first_cyc - b_push_cyc, 2);
      chk("vec_span", b_last_cyc - b_first_cyc, 3);
      chk("vec_sent", b_bytes_sent, vt[i].cnt);
    end
    chk("b_level0", b_level, 0);

    // random TXE# and valid on both DUTs
    na = 0; nb = 0; ta = 0; tb = 0;
    for (int c = 0; c < 8000 && !(na >= 1000 && nb >= 70 &&
         !a_busy && !b_busy && a_exp.size() == 0 && b_exp.size() == 0); c++) begin
      if (a_s_valid && ta) begin na++; a_s_valid = 1'b0; end
      if (!a_s_valid && na < 1000 && $urandom_range(0, 3) != 0) begin
        a_s_valid = 1'b1;
        a_s_data  = 8'($urandom);
      end
      if (b_s_valid && tb) begin nb++; b_s_valid = 1'b0; end
      if (!b_s_valid && nb < 70 && $urandom_range(0, 3) != 0) begin
        b_s_valid = 1'b1;
        b_s_data  = $urandom;
      end
      a_txe_n = 1'($urandom_range(0, 1));
      b_txe_n = 1'($urandom_range(0, 1));
      @(negedge clk);
      ta = a_s_valid && a_s_ready;
      tb = b_s_valid && b_s_ready;
      @(posedge clk); #1;
    end
    a_txe_n = 1'b0;
    b_txe_n = 1'b0;
    chk("rand_a_words", na, 1000);
    chk("rand_b_words", nb, 70);
    wait_idle_a(10);
    wait_idle_b(10);
    chk("rand_b_wrap", b_bytes_sent, 8'(16 + 70 * 4));
    chk("b_never_siwu", b_siwu_cnt, 0);

    // reset in the middle of a transfer
    push_a(8'h71);
    push_a(8'h72);
    #2;
    chk("mid_wr_low", a_wr_n, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_wr_released", a_wr_n, 1);
    chk("mid_level", a_level, 0);
    chk("mid_busy", a_busy, 0);
    chk("mid_sent", a_bytes_sent, 0);
    chk("mid_data", a_data, 0);
    a_exp.delete();
    b_exp.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
